// File: rtl/s1_fetch_pkg.sv
// Shared opcode/control definitions for the three-stage core: the pc_sel redirect
// codes driven by stage-3 control, plus the boot address and bubble instruction.
package s1_fetch_pkg;

  typedef enum logic [1:0] {
    PC_SEL_SEQ   = 2'd0,
    PC_SEL_REDIR = 2'd1,
    PC_SEL_JAL   = 2'd2,
    PC_SEL_RST   = 2'd3
  } pc_sel_e;

  localparam logic [31:0] RESET_PC   = 32'h4000_0000;
  localparam logic [31:0] NOP_INST   = 32'h0000_0013;
  localparam logic [31:0] INST_BYTES = 32'd4;

  // Instruction fetch never traps on misalignment; the low bits are simply dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/s1_fetch_if.sv
// Fetch-stage bundle: stage-3 redirect controls, the IMEM/BIOS read port and the
// instruction hand-off to stage 2. master = fetch unit, slave = its environment.
interface s1_fetch_if;

  logic [1:0]  pc_sel;
  logic [31:0] redirect_target;
  logic [31:0] jal_target;
  logic        stall;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc_s2;
  logic [31:0] inst_s2;
  logic        valid_s2;

  modport master (
    input  pc_sel, redirect_target, jal_target, stall, imem_rdata,
    output imem_en, imem_addr, pc_s2, inst_s2, valid_s2
  );

  modport slave (
    output pc_sel, redirect_target, jal_target, stall, imem_rdata,
    input  imem_en, imem_addr, pc_s2, inst_s2, valid_s2
  );

endinterface

// File: rtl/s1_fetch_pc_next_mux.sv
// Priority select of the next fetch address while running: soft reset, stage-3
// redirect, stage-2 JAL, stall re-read, then sequential.
module pc_next_mux
  import s1_fetch_pkg::*;
(
  input  logic [1:0]  pc_sel,
  input  logic        stall,
  input  logic [31:0] fetch_pc,
  input  logic [31:0] redirect_target,
  input  logic [31:0] jal_target,
  output logic [31:0] next_addr,
  output logic        live,
  output logic        soft_rst
);

  // Redirects outrank stall: the stalled stage-2 word is being squashed anyway.
  always_comb begin
    next_addr = fetch_pc + INST_BYTES;
    live      = 1'b1;
    soft_rst  = 1'b0;
    case (pc_sel_e'(pc_sel))
      PC_SEL_RST: begin
        next_addr = RESET_PC;
        live      = 1'b0;
        soft_rst  = 1'b1;
      end
      PC_SEL_REDIR: begin
        next_addr = word_align(redirect_target);
        live      = 1'b0;
      end
      PC_SEL_JAL: begin
        next_addr = word_align(jal_target);
        live      = 1'b0;
      end
      PC_SEL_SEQ: begin
        if (stall) begin
          next_addr = fetch_pc;
        end else begin
          next_addr = fetch_pc + INST_BYTES;
        end
      end
      default: begin
        next_addr = fetch_pc + INST_BYTES;
        live      = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/s1_fetch.sv
// Stage-1 fetch: holds the PC of the word currently returning from IMEM, presents
// the next address and hands the returned word to stage 2, dropping wrong-path data.
module s1_fetch
  import s1_fetch_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  s1_fetch_if.master    bus
);

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;

  logic [31:0] mux_addr;
  logic        mux_live;
  logic        mux_soft_rst;

  logic        fetch_en;
  logic [31:0] fetch_addr;
  logic        fetch_valid;
  logic [31:0] fetch_pc_out;

  pc_next_mux u_pc_next_mux (
    .pc_sel          (bus.pc_sel),
    .stall           (bus.stall),
    .fetch_pc        (fetch_pc_q),
    .redirect_target (bus.redirect_target),
    .jal_target      (bus.jal_target),
    .next_addr       (mux_addr),
    .live            (mux_live),
    .soft_rst        (mux_soft_rst)
  );

  // Next state and the combinational fetch outputs; reset overrides everything.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    fetch_en     = 1'b1;
    fetch_addr   = RESET_PC;
    fetch_valid  = 1'b0;
    fetch_pc_out = fetch_pc_q;
    if (!rst_n) begin
      fetch_en     = 1'b0;
      fetch_addr   = RESET_PC;
      fetch_valid  = 1'b0;
      fetch_pc_out = RESET_PC;
      state_d      = ST_BOOT;
      fetch_pc_d   = RESET_PC;
    end else begin
      case (state_q)
        ST_BOOT: begin
          fetch_addr = RESET_PC;
          state_d    = ST_RUN;
          fetch_pc_d = RESET_PC;
        end
        ST_RUN: begin
          fetch_addr  = mux_addr;
          fetch_valid = mux_live;
          if (mux_soft_rst) begin
            state_d    = ST_BOOT;
            fetch_pc_d = RESET_PC;
          end else begin
            state_d    = ST_RUN;
            fetch_pc_d = mux_addr;
          end
        end
        default: begin
          state_d    = ST_BOOT;
          fetch_pc_d = RESET_PC;
        end
      endcase
    end
  end

  // State and fetch PC registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_BOOT;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  assign bus.imem_en   = fetch_en;
  assign bus.imem_addr = fetch_addr;
  assign bus.valid_s2  = fetch_valid;
  assign bus.pc_s2     = fetch_pc_out;
  assign bus.inst_s2   = fetch_valid ? bus.imem_rdata : NOP_INST;

endmodule

// File: tb/tb_s1_fetch.sv
// Bench for s1_fetch: directed vector table, a stall-length sequence and a
// randomized run checked against a cycle-level model of the fetch rules.
module tb_s1_fetch;
  import s1_fetch_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  s1_fetch_if bus ();

  s1_fetch dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h4000_0000) return 32'h0010_0093;
    return a ^ 32'hC0DE_0001;
  endfunction

  // Synchronous IMEM: word for the address presented this cycle returns next cycle.
  always @(posedge clk) begin
    if (bus.imem_en) bus.imem_rdata <= mem_word(bus.imem_addr);
  end

  typedef struct {
    logic        rn;
    logic [1:0]  sel;
    logic        st;
    logic [31:0] rt;
    logic [31:0] jt;
    logic        e_en;
    logic [31:0] e_addr;
    logic        c_addr;
    logic        e_valid;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
    logic        c_pc;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  bit          m_boot = 1'b1;
  logic [31:0] m_pc   = 32'h4000_0000;

  logic [31:0] obs_pc;
  logic [31:0] obs_inst;
  logic        obs_valid;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rn, input logic [1:0] sel, input logic st,
                              input logic [31:0] rt, input logic [31:0] jt,
                              input logic en, input logic [31:0] addr, input logic ca,
                              input logic valid, input logic [31:0] inst,
                              input logic [31:0] pc, input logic cp);
    vec_t v;
    v.rn = rn; v.sel = sel; v.st = st; v.rt = rt; v.jt = jt;
    v.e_en = en; v.e_addr = addr; v.c_addr = ca;
    v.e_valid = valid; v.e_inst = inst; v.e_pc = pc; v.c_pc = cp;
    return v;
  endfunction

  // Reference: what stage 1 should show this cycle given the address it presented last cycle.
  function automatic vec_t model_vec(input logic rn, input logic [1:0] sel, input logic st,
                                     input logic [31:0] rt, input logic [31:0] jt);
    vec_t v;
    v = mk(rn, sel, st, rt, jt, 1'b1, 32'h4000_0000, 1'b1, 1'b0, 32'h0000_0013, m_pc, 1'b1);
    if (!rn) begin
      v.e_en = 1'b0;
      v.e_pc = 32'h4000_0000;
    end else if (m_boot) begin
      v.c_pc = 1'b0;
    end else if (sel == 2'd3) begin
      v.c_addr = 1'b0;
    end else if (sel == 2'd1) begin
      v.e_addr = rt & 32'hFFFF_FFFC;
    end else if (sel == 2'd2) begin
      v.e_addr = jt & 32'hFFFF_FFFC;
    end else begin
      v.e_addr  = st ? m_pc : m_pc + 32'd4;
      v.e_valid = 1'b1;
      v.e_inst  = mem_word(m_pc);
    end
    return v;
  endfunction

  task automatic model_step(input vec_t mv);
    if (!mv.rn || m_boot || mv.sel == 2'd3) begin
      m_boot = (!mv.rn || mv.sel == 2'd3) && !(mv.rn && m_boot);
      m_pc   = 32'h4000_0000;
    end else begin
      m_pc = mv.e_addr;
    end
  endtask

  // Entered just after a rising edge; leaves just after the next one.
  task automatic run_vec(input vec_t v, input string ph, input int idx);
    vec_t mv;
    rst_n               = v.rn;
    bus.pc_sel          = v.sel;
    bus.stall           = v.st;
    bus.redirect_target = v.rt;
    bus.jal_target      = v.jt;
    mv = model_vec(v.rn, v.sel, v.st, v.rt, v.jt);
    #2;
    obs_pc    = bus.pc_s2;
    obs_inst  = bus.inst_s2;
    obs_valid = bus.valid_s2;
    cmp($sformatf("%s[%0d].imem_en", ph, idx), {31'd0, bus.imem_en}, {31'd0, v.e_en});
    cmp($sformatf("%s[%0d].valid_s2", ph, idx), {31'd0, bus.valid_s2}, {31'd0, v.e_valid});
    cmp($sformatf("%s[%0d].inst_s2", ph, idx), bus.inst_s2, v.e_inst);
    if (v.c_addr) cmp($sformatf("%s[%0d].imem_addr", ph, idx), bus.imem_addr, v.e_addr);
    if (v.c_pc) cmp($sformatf("%s[%0d].pc_s2", ph, idx), bus.pc_s2, v.e_pc);
    @(posedge clk);
    model_step(mv);
    #1;
  endtask

  task automatic run_model(input logic rn, input logic [1:0] sel, input logic st,
                           input logic [31:0] rt, input logic [31:0] jt,
                           input string ph, input int idx);
    run_vec(model_vec(rn, sel, st, rt, jt), ph, idx);
  endtask

  localparam logic [31:0] R   = 32'h4000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] Z   = 32'h0000_0000;

  vec_t tbl[28];

  initial begin
    tbl[0]  = mk(0, 2'd0, 0, Z, Z, 0, R, 1, 0, NOP, R, 1);
    tbl[1]  = mk(0, 2'd0, 0, Z, Z, 0, R, 1, 0, NOP, R, 1);
    tbl[2]  = mk(1, 2'd0, 0, Z, Z, 1, R, 1, 0, NOP, R, 0);
    tbl[3]  = mk(1, 2'd0, 0, Z, Z, 1, 32'h4000_0004, 1, 1, 32'h0010_0093, R, 1);
    tbl[4]  = mk(1, 2'd0, 0, Z, Z, 1, 32'h4000_0008, 1, 1, mem_word(32'h4000_0004), 32'h4000_0004, 1);
    tbl[5]  = mk(1, 2'd0, 1, Z, Z, 1, 32'h4000_0008, 1, 1, mem_word(32'h4000_0008), 32'h4000_0008, 1);
    tbl[6]  = mk(1, 2'd0, 1, Z, Z, 1, 32'h4000_0008, 1, 1, mem_word(32'h4000_0008), 32'h4000_0008, 1);
    tbl[7]  = mk(1, 2'd0, 1, Z, Z, 1, 32'h4000_0008, 1, 1, mem_word(32'h4000_0008), 32'h4000_0008, 1);
    tbl[8]  = mk(1, 2'd0, 0, Z, Z, 1, 32'h4000_000C, 1, 1, mem_word(32'h4000_0008), 32'h4000_0008, 1);
    tbl[9]  = mk(1, 2'd0, 0, Z, Z, 1, 32'h4000_0010, 1, 1, mem_word(32'h4000_000C), 32'h4000_000C, 1);
    tbl[10] = mk(1, 2'd1, 0, 32'h1000_0102, Z, 1, 32'h1000_0100, 1, 0, NOP, 32'h4000_0010, 1);
    tbl[11] = mk(1, 2'd0, 0, Z, Z, 1, 32'h1000_0104, 1, 1, mem_word(32'h1000_0100), 32'h1000_0100, 1);
    tbl[12] = mk(1, 2'd2, 0, Z, 32'h4000_0203, 1, 32'h4000_0200, 1, 0, NOP, 32'h1000_0104, 1);
    tbl[13] = mk(1, 2'd1, 0, 32'h2000_0001, Z, 1, 32'h2000_0000, 1, 0, NOP, 32'h4000_0200, 1);
    tbl[14] = mk(1, 2'd0, 0, Z, Z, 1, 32'h2000_0004, 1, 1, mem_word(32'h2000_0000), 32'h2000_0000, 1);
    tbl[15] = mk(1, 2'd2, 1, Z, 32'h4000_0100, 1, 32'h4000_0100, 1, 0, NOP, 32'h2000_0004, 1);
    tbl[16] = mk(1, 2'd0, 0, Z, Z, 1, 32'h4000_0104, 1, 1, mem_word(32'h4000_0100), 32'h4000_0100, 1);
    tbl[17] = mk(1, 2'd1, 0, 32'hFFFF_FFFB, Z, 1, 32'hFFFF_FFF8, 1, 0, NOP, 32'h4000_0104, 1);
    tbl[18] = mk(1, 2'd0, 0, Z, Z, 1, 32'hFFFF_FFFC, 1, 1, mem_word(32'hFFFF_FFF8), 32'hFFFF_FFF8, 1);
    tbl[19] = mk(1, 2'd0, 0, Z, Z, 1, 32'h0000_0000, 1, 1, mem_word(32'hFFFF_FFFC), 32'hFFFF_FFFC, 1);
    tbl[20] = mk(1, 2'd0, 0, Z, Z, 1, 32'h0000_0004, 1, 1, mem_word(32'h0000_0000), 32'h0000_0000, 1);
    tbl[21] = mk(1, 2'd3, 0, Z, Z, 1, R, 0, 0, NOP, 32'h0000_0004, 1);
    tbl[22] = mk(1, 2'd0, 0, Z, Z, 1, R, 1, 0, NOP, R, 0);
    tbl[23] = mk(1, 2'd0, 0, Z, Z, 1, 32'h4000_0004, 1, 1, 32'h0010_0093, R, 1);
    tbl[24] = mk(1, 2'd0, 1, Z, Z, 1, 32'h4000_0004, 1, 1, mem_word(32'h4000_0004), 32'h4000_0004, 1);
    tbl[25] = mk(0, 2'd0, 1, Z, Z, 0, R, 1, 0, NOP, R, 1);
    tbl[26] = mk(1, 2'd1, 0, 32'h1234_5678, Z, 1, R, 1, 0, NOP, R, 0);
    tbl[27] = mk(1, 2'd0, 0, Z, Z, 1, 32'h4000_0004, 1, 1, 32'h0010_0093, R, 1);

    rst_n = 1'b0;
    bus.pc_sel = 2'd0; bus.stall = 1'b0;
    bus.redirect_target = Z; bus.jal_target = Z;
    @(posedge clk);
    #1;

    for (int i = 0; i < 28; i++) run_vec(tbl[i], "table", i);

    // Randomized run; occasional reset pulses and targets near the top of memory.
    for (int i = 0; i < 400; i++) begin
      logic        rn;
      logic [1:0]  sel;
      logic        st;
      logic [31:0] rt;
      int          r;
      rn = ($urandom_range(0, 39) != 0);
      r  = $urandom_range(0, 19);
      sel = (r < 14) ? 2'd0 : (r < 16) ? 2'd1 : (r < 18) ? 2'd2 : 2'd3;
      st = ($urandom_range(0, 3) == 0);
      rt = $urandom;
      if ($urandom_range(0, 7) == 0) rt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      run_model(rn, sel, st, rt, $urandom, "rand", i);
    end

    // Stall held N cycles: the same word is shown N+1 times, then fetch moves on.
    for (int n = 1; n <= 4; n++) begin
      logic [31:0] p0;
      logic [31:0] i0;
      int          same;
      run_model(1'b0, 2'd0, 1'b0, Z, Z, "stallseq", n);
      for (int k = 0; k < 3; k++) run_model(1'b1, 2'd0, 1'b0, Z, Z, "stallseq", n);
      same = 0;
      p0 = Z;
      i0 = Z;
      for (int k = 0; k <= n + 1; k++) begin
        run_model(1'b1, 2'd0, (k < n), Z, Z, "stallseq", n);
        if (k == 0) begin
          p0 = obs_pc;
          i0 = obs_inst;
        end
        if (obs_valid && obs_pc == p0 && obs_inst == i0) same++;
      end
      cmp($sformatf("stallseq[%0d].repeat_count", n), 32'(same), 32'(n + 1));
      cmp($sformatf("stallseq[%0d].first_pc", n), p0, 32'h4000_0008);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
